// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings, FSM state and lane helpers for the memory access unit
package riscv_pkg;

    // StoreSrcM encodings
    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    // LoadPartM encodings
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mau_state_e;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10,
        ACC_RSVD = 2'b11
    } acc_width_e;

    function automatic acc_width_e store_width(input logic [1:0] src);
        case (src)
            STORE_SB: return ACC_BYTE;
            STORE_SH: return ACC_HALF;
            STORE_SW: return ACC_WORD;
            default:  return ACC_RSVD;
        endcase
    endfunction

    function automatic acc_width_e load_width(input logic [2:0] part);
        case (part)
            LOAD_LB, LOAD_LBU: return ACC_BYTE;
            LOAD_LH, LOAD_LHU: return ACC_HALF;
            LOAD_LW:           return ACC_WORD;
            default:           return ACC_RSVD;
        endcase
    endfunction

    // Byte enables for an access of width w starting at byte offset off
    function automatic logic [3:0] byte_enable(input acc_width_e w, input logic [1:0] off);
        case (w)
            ACC_BYTE: return 4'b0001 << off;
            ACC_HALF: return off[1] ? 4'b1100 : 4'b0011;
            ACC_WORD: return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane selection and sign/zero extension
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_load_part,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte lane out of the read word
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extend the selected lane according to the load type
    always_comb begin
        case (i_load_part)
            LOAD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LH:  o_data = {{16{w_half[15]}}, w_half};
            LOAD_LW:  o_data = i_rdata;
            LOAD_LBU: o_data = {24'h0, w_byte};
            LOAD_LHU: o_data = {16'h0, w_half};
            default:  o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store sequencer with stall, alignment faults and lane steering
module mem_access_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  StoreSrcM,
    input  logic [2:0]  LoadPartM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        FaultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    mau_state_e  r_state;
    mau_state_e  w_next_state;

    logic        r_req;
    logic        r_we;
    logic [29:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_offset;
    logic [2:0]  r_load_part;
    logic [31:0] r_rdata;

    acc_width_e  w_width;
    logic        w_fault_cond;
    logic        w_start;
    logic [31:0] w_store_lanes;
    logic [31:0] w_ext;

    // Width comes from the store or load encoding depending on direction
    assign w_width = MemWriteM ? store_width(StoreSrcM) : load_width(LoadPartM);

    assign w_fault_cond = (w_width == ACC_RSVD)
                        | ((w_width == ACC_HALF) & ALUResultM[0])
                        | ((w_width == ACC_WORD) & (ALUResultM[1:0] != 2'b00));

    assign FaultM  = MemReqM & w_fault_cond;
    assign w_start = (r_state == ST_IDLE) & MemReqM & ~FaultM;

    // Replicate the store value across every lane it could land in
    always_comb begin
        case (StoreSrcM)
            STORE_SB: w_store_lanes = {4{WriteDataM[7:0]}};
            STORE_SH: w_store_lanes = {2{WriteDataM[15:0]}};
            default:  w_store_lanes = WriteDataM;
        endcase
    end

    load_extend u_load_extend (
        .i_rdata     (dmem_rdata),
        .i_offset    (r_offset),
        .i_load_part (r_load_part),
        .o_data      (w_ext)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next-state logic; gnt and rvalid only matter in their own states
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start)     w_next_state = ST_REQ;
            ST_REQ:  if (dmem_gnt)    w_next_state = r_we ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem_rvalid) w_next_state = ST_DONE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: stall everywhere except DONE, and in IDLE only when accepting
    always_comb begin
        StallM = 1'b0;
        case (r_state)
            ST_IDLE: StallM = w_start;
            ST_REQ:  StallM = 1'b1;
            ST_WAIT: StallM = 1'b1;
            default: StallM = 1'b0;
        endcase
    end

    // Request register: captured at acceptance, held until the grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 30'h0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_offset    <= 2'b00;
            r_load_part <= 3'b000;
            r_rdata     <= 32'h0;
        end else begin
            if (w_start) begin
                r_req       <= 1'b1;
                r_we        <= MemWriteM;
                r_addr      <= ALUResultM[31:2];
                r_be        <= byte_enable(w_width, ALUResultM[1:0]);
                r_wdata     <= MemWriteM ? w_store_lanes : 32'h0;
                r_offset    <= ALUResultM[1:0];
                r_load_part <= LoadPartM;
            end else if ((r_state == ST_REQ) && dmem_gnt) begin
                r_req <= 1'b0;
            end
            if ((r_state == ST_WAIT) && dmem_rvalid) begin
                r_rdata <= w_ext;
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr, 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign ReadDataM  = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [1:0]  StoreSrcM;
    logic [2:0]  LoadPartM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        FaultM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int passed = 0;
    int total  = 0;
    logic [31:0] last_rd;

    mem_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .MemReqM     (MemReqM),
        .MemWriteM   (MemWriteM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .StoreSrcM   (StoreSrcM),
        .LoadPartM   (LoadPartM),
        .StallM      (StallM),
        .ReadDataM   (ReadDataM),
        .FaultM      (FaultM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  src;
        logic [2:0]  part;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_delay;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] src, input logic [2:0] part,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt_delay, input logic fault,
                                input logic [3:0] be, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_rd, input int stall);
        vec_t v;
        v.we = we; v.src = src; v.part = part; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gnt_delay = gnt_delay; v.fault = fault; v.be = be;
        v.exp_wdata = exp_wdata; v.exp_rd = exp_rd; v.stall = stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   stall_cnt;
        int   wait_cnt;
        bit   granted;
        bit   rv_sent;
        bit   unstable;
        bit   seen;
        bit   done;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic [3:0]  be0;
        logic        we0;
        stall_cnt = 0; wait_cnt = 0; granted = 0; rv_sent = 0;
        unstable = 0; seen = 0; done = 0;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;

        MemReqM = 1'b1; MemWriteM = v.we; StoreSrcM = v.src; LoadPartM = v.part;
        ALUResultM = v.addr; WriteDataM = v.wdata;
        #1;
        check($sformatf("v%0d_fault", idx), {31'h0, FaultM}, {31'h0, v.fault});
        if (v.fault) begin
            check($sformatf("v%0d_fault_stall", idx), {31'h0, StallM}, 32'h0);
            @(negedge clk); #1;
            check($sformatf("v%0d_fault_noreq", idx), {31'h0, dmem_req}, 32'h0);
            check($sformatf("v%0d_fault_rd", idx), ReadDataM, last_rd);
            MemReqM = 1'b0;
            return;
        end

        for (int c = 0; c < 40 && !done; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (!StallM) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (dmem_req) begin
                    if (!seen) begin
                        seen = 1; a0 = dmem_addr; be0 = dmem_be; we0 = dmem_we; wd0 = dmem_wdata;
                    end else if ({dmem_addr, dmem_be, dmem_we, dmem_wdata} !== {a0, be0, we0, wd0}) begin
                        unstable = 1;
                    end
                    if (wait_cnt == v.gnt_delay) begin
                        dmem_gnt = 1'b1; granted = 1;
                    end else begin
                        wait_cnt++;
                    end
                end else if (granted && !v.we && !rv_sent) begin
                    dmem_rvalid = 1'b1; dmem_rdata = v.rdata; rv_sent = 1;
                end
                @(negedge clk); #1;
            end
        end

        check($sformatf("v%0d_done_reached", idx), {31'h0, done}, 32'h1);
        check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.stall);
        check($sformatf("v%0d_be", idx), {28'h0, be0}, {28'h0, v.be});
        check($sformatf("v%0d_addr", idx), a0, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d_we", idx), {31'h0, we0}, {31'h0, v.we});
        check($sformatf("v%0d_stable", idx), {31'h0, unstable}, 32'h0);
        if (v.we) begin
            check($sformatf("v%0d_wdata", idx), wd0, v.exp_wdata);
        end else begin
            check($sformatf("v%0d_rdata", idx), ReadDataM, v.exp_rd);
            last_rd = v.exp_rd;
        end

        @(negedge clk);
        MemReqM = 1'b0;
        #1;
        check($sformatf("v%0d_idle_stall", idx), {31'h0, StallM}, 32'h0);
        check($sformatf("v%0d_idle_noreq", idx), {31'h0, dmem_req}, 32'h0);
        check($sformatf("v%0d_rd_hold", idx), ReadDataM, last_rd);
    endtask

    initial begin
        reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
        StoreSrcM = 2'b00; LoadPartM = 3'b000; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0; last_rd = '0;

        //                we    src    part    addr          wdata         rdata        dly flt be       exp_wdata     exp_rd      stall
        vecs.push_back(mk(1'b1, 2'b10, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0,        2));
        vecs.push_back(mk(1'b0, 2'b00, 3'b000, 32'h0000_2002, 32'h0,        32'h0080_FF00, 0, 0, 4'b0100, 32'h0,        32'hFFFF_FF80, 3));
        vecs.push_back(mk(1'b0, 2'b00, 3'b100, 32'h0000_2002, 32'h0,        32'h0080_FF00, 0, 0, 4'b0100, 32'h0,        32'h0000_0080, 3));
        vecs.push_back(mk(1'b0, 2'b00, 3'b001, 32'h0000_3001, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1'b0, 2'b00, 3'b010, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 4, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 7));
        vecs.push_back(mk(1'b0, 2'b00, 3'b101, 32'h0000_5002, 32'h0,        32'h8001_1234, 0, 0, 4'b1100, 32'h0,        32'h0000_8001, 3));
        vecs.push_back(mk(1'b0, 2'b00, 3'b001, 32'h0000_5002, 32'h0,        32'h8001_1234, 0, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 3));
        vecs.push_back(mk(1'b1, 2'b01, 3'b000, 32'h0000_6002, 32'h1234_ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,        2));
        vecs.push_back(mk(1'b1, 2'b00, 3'b000, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,        0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        2));
        vecs.push_back(mk(1'b1, 2'b00, 3'b000, 32'h0000_7002, 32'h1111_1111, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1'b1, 2'b11, 3'b000, 32'h0000_8000, 32'h1111_1111, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1'b0, 2'b00, 3'b011, 32'h0000_8000, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1'b0, 2'b00, 3'b100, 32'h0000_9001, 32'h0,        32'h1122_3344, 0, 0, 4'b0010, 32'h0,        32'h0000_0033, 3));
        vecs.push_back(mk(1'b0, 2'b00, 3'b001, 32'h0000_9000, 32'h0,        32'h0000_F00F, 0, 0, 4'b0011, 32'h0,        32'hFFFF_F00F, 3));
        vecs.push_back(mk(1'b1, 2'b10, 3'b000, 32'h0000_9000, 32'h0000_005A, 32'h0,        2, 0, 4'b0001, 32'h5A5A_5A5A, 32'h0,        4));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req",   {31'h0, dmem_req}, 32'h0);
        check("rst_we",    {31'h0, dmem_we}, 32'h0);
        check("rst_be",    {28'h0, dmem_be}, 32'h0);
        check("rst_addr",  dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_stall", {31'h0, StallM}, 32'h0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
            @(negedge clk);
        end

        // rvalid and gnt while idle must not disturb anything
        dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        #1;
        check("idle_rvalid_rd",  ReadDataM, last_rd);
        check("idle_gnt_noreq",  {31'h0, dmem_req}, 32'h0);
        check("idle_stall",      {31'h0, StallM}, 32'h0);

        // Reset while waiting for read data, then a late rvalid
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b0; LoadPartM = 3'b010; ALUResultM = 32'h0000_A000;
        @(negedge clk); #1;
        check("rstw_req", {31'h0, dmem_req}, 32'h1);
        dmem_gnt = 1'b1;
        @(negedge clk); #1;
        dmem_gnt = 1'b0;
        check("rstw_wait_stall", {31'h0, StallM}, 32'h1);
        reset = 1'b1; MemReqM = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        check("rstw_stall_after", {31'h0, StallM}, 32'h0);
        @(negedge clk); #1;
        dmem_rvalid = 1'b0;
        check("rstw_rd_zero",  ReadDataM, 32'h0);
        check("rstw_no_done",  {31'h0, StallM}, 32'h0);
        check("rstw_noreq",    {31'h0, dmem_req}, 32'h0);
        check("rstw_be_zero",  {28'h0, dmem_be}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
